// File: rtl/pipe_regs_if_ex_if.sv
// Signal bundle for the IF/ID, ID/EX and EX/MEM pipeline register banks.
// The master drives enables and stage inputs; the slave (register block) returns stage outputs.
interface pipe_regs_if_ex_if;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;

    logic [31:0] if_instr_d;
    logic [63:0] if_pc_d;
    logic [31:0] id_instr_q;
    logic [63:0] id_pc_q;

    logic [63:0] id_rd1_d;
    logic [63:0] id_rd2_d;
    logic [63:0] id_se_d;
    logic [4:0]  id_rn_d;
    logic [4:0]  id_rm_d;
    logic [4:0]  id_rd_d;
    logic [5:0]  id_ex_ctl_d;
    logic [4:0]  id_m_ctl_d;
    logic [1:0]  id_wb_ctl_d;
    logic [63:0] ex_rd1_q;
    logic [63:0] ex_rd2_q;
    logic [63:0] ex_se_q;
    logic [63:0] ex_pc_q;
    logic [4:0]  ex_rn_q;
    logic [4:0]  ex_rm_q;
    logic [4:0]  ex_rd_q;
    logic [5:0]  ex_ex_ctl_q;
    logic [4:0]  ex_m_ctl_q;
    logic [1:0]  ex_wb_ctl_q;

    logic [63:0] ex_alu_result_d;
    logic [63:0] ex_write_data_d;
    logic [63:0] ex_addr_d;
    logic [3:0]  ex_alu_flags_d;
    logic [3:0]  ex_reg_flags_d;
    logic [63:0] mem_alu_result_q;
    logic [63:0] mem_write_data_q;
    logic [63:0] mem_addr_q;
    logic [3:0]  mem_alu_flags_q;
    logic [3:0]  mem_reg_flags_q;
    logic [4:0]  mem_rd_q;
    logic [4:0]  mem_m_ctl_q;
    logic [1:0]  mem_wb_ctl_q;

    modport master (
        output if_id_en, id_ex_en, ex_mem_en,
        output if_instr_d, if_pc_d,
        output id_rd1_d, id_rd2_d, id_se_d, id_rn_d, id_rm_d, id_rd_d,
        output id_ex_ctl_d, id_m_ctl_d, id_wb_ctl_d,
        output ex_alu_result_d, ex_write_data_d, ex_addr_d, ex_alu_flags_d, ex_reg_flags_d,
        input  id_instr_q, id_pc_q,
        input  ex_rd1_q, ex_rd2_q, ex_se_q, ex_pc_q, ex_rn_q, ex_rm_q, ex_rd_q,
        input  ex_ex_ctl_q, ex_m_ctl_q, ex_wb_ctl_q,
        input  mem_alu_result_q, mem_write_data_q, mem_addr_q, mem_alu_flags_q,
        input  mem_reg_flags_q, mem_rd_q, mem_m_ctl_q, mem_wb_ctl_q
    );

    modport slave (
        input  if_id_en, id_ex_en, ex_mem_en,
        input  if_instr_d, if_pc_d,
        input  id_rd1_d, id_rd2_d, id_se_d, id_rn_d, id_rm_d, id_rd_d,
        input  id_ex_ctl_d, id_m_ctl_d, id_wb_ctl_d,
        input  ex_alu_result_d, ex_write_data_d, ex_addr_d, ex_alu_flags_d, ex_reg_flags_d,
        output id_instr_q, id_pc_q,
        output ex_rd1_q, ex_rd2_q, ex_se_q, ex_pc_q, ex_rn_q, ex_rm_q, ex_rd_q,
        output ex_ex_ctl_q, ex_m_ctl_q, ex_wb_ctl_q,
        output mem_alu_result_q, mem_write_data_q, mem_addr_q, mem_alu_flags_q,
        output mem_reg_flags_q, mem_rd_q, mem_m_ctl_q, mem_wb_ctl_q
    );
endinterface

// File: rtl/pipe_regs_if_ex.sv
// IF/ID, ID/EX and EX/MEM pipeline register banks with per-stage enables.
// PC, Rd and M/WB control are chained internally between stages; reset produces bubbles.
module pipe_regs_if_ex (
    input logic                 clk,
    input logic                 rst,
    pipe_regs_if_ex_if.slave    bus
);
    logic [31:0] id_instr_q, id_instr_d;
    logic [63:0] id_pc_q, id_pc_d;

    logic [63:0] ex_rd1_q, ex_rd1_d;
    logic [63:0] ex_rd2_q, ex_rd2_d;
    logic [63:0] ex_se_q, ex_se_d;
    logic [63:0] ex_pc_q, ex_pc_d;
    logic [4:0]  ex_rn_q, ex_rn_d;
    logic [4:0]  ex_rm_q, ex_rm_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [5:0]  ex_ex_ctl_q, ex_ex_ctl_d;
    logic [4:0]  ex_m_ctl_q, ex_m_ctl_d;
    logic [1:0]  ex_wb_ctl_q, ex_wb_ctl_d;

    logic [63:0] mem_alu_result_q, mem_alu_result_d;
    logic [63:0] mem_write_data_q, mem_write_data_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_alu_flags_q, mem_alu_flags_d;
    logic [3:0]  mem_reg_flags_q, mem_reg_flags_d;
    logic [4:0]  mem_rd_q, mem_rd_d;
    logic [4:0]  mem_m_ctl_q, mem_m_ctl_d;
    logic [1:0]  mem_wb_ctl_q, mem_wb_ctl_d;

    always_comb begin
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (bus.if_id_en) begin
            id_instr_d = bus.if_instr_d;
            id_pc_d    = bus.if_pc_d;
        end
    end

    // ex_pc takes the IF/ID output, so a stalled IF/ID is repeated downstream.
    always_comb begin
        ex_rd1_d    = ex_rd1_q;
        ex_rd2_d    = ex_rd2_q;
        ex_se_d     = ex_se_q;
        ex_pc_d     = ex_pc_q;
        ex_rn_d     = ex_rn_q;
        ex_rm_d     = ex_rm_q;
        ex_rd_d     = ex_rd_q;
        ex_ex_ctl_d = ex_ex_ctl_q;
        ex_m_ctl_d  = ex_m_ctl_q;
        ex_wb_ctl_d = ex_wb_ctl_q;
        if (bus.id_ex_en) begin
            ex_rd1_d    = bus.id_rd1_d;
            ex_rd2_d    = bus.id_rd2_d;
            ex_se_d     = bus.id_se_d;
            ex_pc_d     = id_pc_q;
            ex_rn_d     = bus.id_rn_d;
            ex_rm_d     = bus.id_rm_d;
            ex_rd_d     = bus.id_rd_d;
            ex_ex_ctl_d = bus.id_ex_ctl_d;
            ex_m_ctl_d  = bus.id_m_ctl_d;
            ex_wb_ctl_d = bus.id_wb_ctl_d;
        end
    end

    always_comb begin
        mem_alu_result_d = mem_alu_result_q;
        mem_write_data_d = mem_write_data_q;
        mem_addr_d       = mem_addr_q;
        mem_alu_flags_d  = mem_alu_flags_q;
        mem_reg_flags_d  = mem_reg_flags_q;
        mem_rd_d         = mem_rd_q;
        mem_m_ctl_d      = mem_m_ctl_q;
        mem_wb_ctl_d     = mem_wb_ctl_q;
        if (bus.ex_mem_en) begin
            mem_alu_result_d = bus.ex_alu_result_d;
            mem_write_data_d = bus.ex_write_data_d;
            mem_addr_d       = bus.ex_addr_d;
            mem_alu_flags_d  = bus.ex_alu_flags_d;
            mem_reg_flags_d  = bus.ex_reg_flags_d;
            mem_rd_d         = ex_rd_q;
            mem_m_ctl_d      = ex_m_ctl_q;
            mem_wb_ctl_d     = ex_wb_ctl_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instr_q       <= '0;
            id_pc_q          <= '0;
            ex_rd1_q         <= '0;
            ex_rd2_q         <= '0;
            ex_se_q          <= '0;
            ex_pc_q          <= '0;
            ex_rn_q          <= '0;
            ex_rm_q          <= '0;
            ex_rd_q          <= '0;
            ex_ex_ctl_q      <= '0;
            ex_m_ctl_q       <= '0;
            ex_wb_ctl_q      <= '0;
            mem_alu_result_q <= '0;
            mem_write_data_q <= '0;
            mem_addr_q       <= '0;
            mem_alu_flags_q  <= '0;
            mem_reg_flags_q  <= '0;
            mem_rd_q         <= '0;
            mem_m_ctl_q      <= '0;
            mem_wb_ctl_q     <= '0;
        end else begin
            id_instr_q       <= id_instr_d;
            id_pc_q          <= id_pc_d;
            ex_rd1_q         <= ex_rd1_d;
            ex_rd2_q         <= ex_rd2_d;
            ex_se_q          <= ex_se_d;
            ex_pc_q          <= ex_pc_d;
            ex_rn_q          <= ex_rn_d;
            ex_rm_q          <= ex_rm_d;
            ex_rd_q          <= ex_rd_d;
            ex_ex_ctl_q      <= ex_ex_ctl_d;
            ex_m_ctl_q       <= ex_m_ctl_d;
            ex_wb_ctl_q      <= ex_wb_ctl_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_write_data_q <= mem_write_data_d;
            mem_addr_q       <= mem_addr_d;
            mem_alu_flags_q  <= mem_alu_flags_d;
            mem_reg_flags_q  <= mem_reg_flags_d;
            mem_rd_q         <= mem_rd_d;
            mem_m_ctl_q      <= mem_m_ctl_d;
            mem_wb_ctl_q     <= mem_wb_ctl_d;
        end
    end

    assign bus.id_instr_q       = id_instr_q;
    assign bus.id_pc_q          = id_pc_q;
    assign bus.ex_rd1_q         = ex_rd1_q;
    assign bus.ex_rd2_q         = ex_rd2_q;
    assign bus.ex_se_q          = ex_se_q;
    assign bus.ex_pc_q          = ex_pc_q;
    assign bus.ex_rn_q          = ex_rn_q;
    assign bus.ex_rm_q          = ex_rm_q;
    assign bus.ex_rd_q          = ex_rd_q;
    assign bus.ex_ex_ctl_q      = ex_ex_ctl_q;
    assign bus.ex_m_ctl_q       = ex_m_ctl_q;
    assign bus.ex_wb_ctl_q      = ex_wb_ctl_q;
    assign bus.mem_alu_result_q = mem_alu_result_q;
    assign bus.mem_write_data_q = mem_write_data_q;
    assign bus.mem_addr_q       = mem_addr_q;
    assign bus.mem_alu_flags_q  = mem_alu_flags_q;
    assign bus.mem_reg_flags_q  = mem_reg_flags_q;
    assign bus.mem_rd_q         = mem_rd_q;
    assign bus.mem_m_ctl_q      = mem_m_ctl_q;
    assign bus.mem_wb_ctl_q     = mem_wb_ctl_q;
endmodule

// File: tb/tb_pipe_regs_if_ex.sv
// Randomized and directed bench for pipe_regs_if_ex; a stage-level model predicts every
// output after each edge and a monitor compares on the falling edge.
module tb_pipe_regs_if_ex;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_regs_if_ex_if bus ();

    pipe_regs_if_ex dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } ifid_t;

    typedef struct packed {
        logic [63:0] rd1, rd2, se, pc;
        logic [4:0]  rn, rm, rd;
        logic [5:0]  ex_ctl;
        logic [4:0]  m_ctl;
        logic [1:0]  wb_ctl;
    } idex_t;

    typedef struct packed {
        logic [63:0] alu_result, write_data, addr;
        logic [3:0]  alu_flags, reg_flags;
        logic [4:0]  rd, m_ctl;
        logic [1:0]  wb_ctl;
    } exmem_t;

    typedef struct packed {
        ifid_t  ifid;
        idex_t  idex;
        exmem_t exmem;
    } pipe_t;

    pipe_t model;
    pipe_t sb[$];
    int    checks = 0;
    int    passes = 0;

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Each stage latches what its producer offers this edge; stages read the old upstream state.
    function automatic pipe_t advance(pipe_t s);
        pipe_t n = s;
        if (bus.if_id_en) n.ifid = '{instr: bus.if_instr_d, pc: bus.if_pc_d};
        if (bus.id_ex_en)
            n.idex = '{rd1: bus.id_rd1_d, rd2: bus.id_rd2_d, se: bus.id_se_d, pc: s.ifid.pc,
                       rn: bus.id_rn_d, rm: bus.id_rm_d, rd: bus.id_rd_d,
                       ex_ctl: bus.id_ex_ctl_d, m_ctl: bus.id_m_ctl_d,
                       wb_ctl: bus.id_wb_ctl_d};
        if (bus.ex_mem_en)
            n.exmem = '{alu_result: bus.ex_alu_result_d, write_data: bus.ex_write_data_d,
                        addr: bus.ex_addr_d, alu_flags: bus.ex_alu_flags_d,
                        reg_flags: bus.ex_reg_flags_d, rd: s.idex.rd,
                        m_ctl: s.idex.m_ctl, wb_ctl: s.idex.wb_ctl};
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic compare_all(input pipe_t e);
        chk("id_instr_q", 64'(bus.id_instr_q), 64'(e.ifid.instr));
        chk("id_pc_q", bus.id_pc_q, e.ifid.pc);
        chk("ex_rd1_q", bus.ex_rd1_q, e.idex.rd1);
        chk("ex_rd2_q", bus.ex_rd2_q, e.idex.rd2);
        chk("ex_se_q", bus.ex_se_q, e.idex.se);
        chk("ex_pc_q", bus.ex_pc_q, e.idex.pc);
        chk("ex_rn_q", 64'(bus.ex_rn_q), 64'(e.idex.rn));
        chk("ex_rm_q", 64'(bus.ex_rm_q), 64'(e.idex.rm));
        chk("ex_rd_q", 64'(bus.ex_rd_q), 64'(e.idex.rd));
        chk("ex_ex_ctl_q", 64'(bus.ex_ex_ctl_q), 64'(e.idex.ex_ctl));
        chk("ex_m_ctl_q", 64'(bus.ex_m_ctl_q), 64'(e.idex.m_ctl));
        chk("ex_wb_ctl_q", 64'(bus.ex_wb_ctl_q), 64'(e.idex.wb_ctl));
        chk("mem_alu_result_q", bus.mem_alu_result_q, e.exmem.alu_result);
        chk("mem_write_data_q", bus.mem_write_data_q, e.exmem.write_data);
        chk("mem_addr_q", bus.mem_addr_q, e.exmem.addr);
        chk("mem_alu_flags_q", 64'(bus.mem_alu_flags_q), 64'(e.exmem.alu_flags));
        chk("mem_reg_flags_q", 64'(bus.mem_reg_flags_q), 64'(e.exmem.reg_flags));
        chk("mem_rd_q", 64'(bus.mem_rd_q), 64'(e.exmem.rd));
        chk("mem_m_ctl_q", 64'(bus.mem_m_ctl_q), 64'(e.exmem.m_ctl));
        chk("mem_wb_ctl_q", 64'(bus.mem_wb_ctl_q), 64'(e.exmem.wb_ctl));
    endtask

    // Monitor: every registered edge produces one expected snapshot.
    always @(negedge clk) begin
        if (sb.size() > 0) compare_all(sb.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        model = rst ? '0 : advance(model);
        sb.push_back(model);
        @(negedge clk);
        #1;
    endtask

    task automatic rand_inputs(input bit rand_en);
        bus.if_instr_d      = $urandom();
        bus.if_pc_d         = rnd64();
        bus.id_rd1_d        = rnd64();
        bus.id_rd2_d        = rnd64();
        bus.id_se_d         = rnd64();
        bus.id_rn_d         = 5'($urandom());
        bus.id_rm_d         = 5'($urandom());
        bus.id_rd_d         = 5'($urandom());
        bus.id_ex_ctl_d     = 6'($urandom());
        bus.id_m_ctl_d      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom());
        bus.id_wb_ctl_d     = 2'($urandom());
        bus.ex_alu_result_d = rnd64();
        bus.ex_write_data_d = rnd64();
        bus.ex_addr_d       = rnd64();
        bus.ex_alu_flags_d  = 4'($urandom());
        bus.ex_reg_flags_d  = 4'($urandom());
        if (rand_en) begin
            bus.if_id_en  = ($urandom_range(0, 3) != 0);
            bus.id_ex_en  = ($urandom_range(0, 3) != 0);
            bus.ex_mem_en = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic set_en(input bit a, input bit b, input bit c);
        bus.if_id_en  = a;
        bus.id_ex_en  = b;
        bus.ex_mem_en = c;
    endtask

    task automatic chk_all_zero(input string tag);
        pipe_t z = '0;
        $display("checking all outputs zero: %s", tag);
        compare_all(z);
    endtask

    initial begin
        model = '0;
        set_en(1'b1, 1'b1, 1'b1);
        rand_inputs(1'b0);
        tick();
        tick();
        #1 rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            rand_inputs(1'b1);
            tick();
        end

        // Asynchronous reset in the middle of a cycle with nonzero inputs.
        set_en(1'b1, 1'b1, 1'b1);
        rand_inputs(1'b0);
        tick();
        tick();
        bus.if_pc_d    = 64'h40;
        bus.id_m_ctl_d = 5'h1F;
        #1 rst = 1'b1;
        model = '0;
        #1 chk_all_zero("async reset");
        tick();
        rst = 1'b0;
        #1 chk_all_zero("after rst falls, before edge");

        // Flow-through of PC.
        bus.if_pc_d = 64'h10;
        tick();
        chk("flow id_pc e1", bus.id_pc_q, 64'h10);
        bus.if_pc_d = 64'h14;
        tick();
        chk("flow ex_pc e2", bus.ex_pc_q, 64'h10);
        chk("flow id_pc e2", bus.id_pc_q, 64'h14);
        bus.if_pc_d = 64'h18;
        tick();
        chk("flow ex_pc e3", bus.ex_pc_q, 64'h14);

        // Rd and M/WB control chaining into EX/MEM.
        bus.id_rd_d     = 5'd7;
        bus.id_m_ctl_d  = 5'b01000;
        bus.id_wb_ctl_d = 2'b10;
        tick();
        bus.id_m_ctl_d = 5'd0;
        tick();
        chk("chain mem_rd", 64'(bus.mem_rd_q), 64'd7);
        chk("chain mem_m_ctl", 64'(bus.mem_m_ctl_q), 64'(5'b01000));
        chk("chain mem_wb_ctl", 64'(bus.mem_wb_ctl_q), 64'(2'b10));
        tick();
        chk("chain mem_m_ctl bubble", 64'(bus.mem_m_ctl_q), 64'd0);

        // IF/ID stall.
        bus.if_instr_d = 32'hF840_03E9;
        tick();
        bus.if_id_en   = 1'b0;
        bus.if_instr_d = 32'h8B02_0020;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall id_instr", 64'(bus.id_instr_q), 64'hF840_03E9);
        end
        bus.if_id_en = 1'b1;
        tick();
        chk("stall release id_instr", 64'(bus.id_instr_q), 64'h8B02_0020);

        // EX/MEM data and flags.
        bus.ex_alu_result_d = 64'hFFFF_FFFF_FFFF_FFFE;
        bus.ex_alu_flags_d  = 4'b1000;
        bus.ex_reg_flags_d  = 4'b0110;
        bus.ex_addr_d       = 64'h100;
        tick();
        chk("mem_alu_result", bus.mem_alu_result_q, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mem_alu_flags", 64'(bus.mem_alu_flags_q), 64'(4'b1000));
        chk("mem_reg_flags", 64'(bus.mem_reg_flags_q), 64'(4'b0110));
        chk("mem_addr", bus.mem_addr_q, 64'h100);

        // EX/MEM held while the upstream stages keep advancing.
        for (int i = 0; i < 4; i++) begin
            rand_inputs(1'b0);
            set_en(1'b1, 1'b1, 1'b0);
            tick();
            chk("hold mem_alu_result", bus.mem_alu_result_q, 64'hFFFF_FFFF_FFFF_FFFE);
            chk("hold mem_addr", bus.mem_addr_q, 64'h100);
        end

        for (int i = 0; i < 150; i++) begin
            rand_inputs(1'b1);
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pipe_regs_if_ex.md
# pipe_regs_if_ex

Bundled pipeline registers for the 5-stage 64-bit ARMv8-subset pipelined CPU: IF/ID, ID/EX and EX/MEM. Each stage is an independently enabled bank of edge-triggered flops. Where a field moves unchanged between these stages, the block chains it internally (PC into ID/EX; Rd and M/WB control into EX/MEM). MEM/WB is a separate block.

## Interface
- No parameters. Widths are fixed: 64-bit datapath, 32-bit instruction, 5-bit register specifiers.
- clk  in  1  single clock; every flop captures on its rising edge.
- rst  in  1  asynchronous, active-high reset; clears all stages.
- if_id_en, id_ex_en, ex_mem_en  in  1 each  per-stage capture enables.
- if_instr_d / id_instr_q  in/out  32  fetched instruction into IF/ID, and the IF/ID output.
- if_pc_d / id_pc_q  in/out  64  fetch PC into IF/ID, and the IF/ID output.
- id_rd1_d, id_rd2_d / ex_rd1_q, ex_rd2_q  in/out  64  register-file read data.
- id_se_d / ex_se_q  in/out  64  sign-extended immediate.
- ex_pc_q  out  64  ID/EX copy of id_pc_q, used for branch target computation.
- id_rn_d, id_rm_d, id_rd_d / ex_rn_q, ex_rm_q, ex_rd_q  in/out  5  register specifiers (instr[9:5], [20:16], [4:0]).
- id_ex_ctl_d / ex_ex_ctl_q  in/out  6  EX control: [2:0] ALUOp, [3] ALUSrc, [4] ShiftDir, [5] FlagEn.
- id_m_ctl_d / ex_m_ctl_q  in/out  5  M control: [0] MemRead, [1] MemWrite, [2] UBranch, [3] Branch, [4] Brsel.
- id_wb_ctl_d / ex_wb_ctl_q  in/out  2  WB control: [0] MemtoReg, [1] RegWrite.
- ex_alu_result_d / mem_alu_result_q  in/out  64  ALU result.
- ex_write_data_d / mem_write_data_q  in/out  64  forwarded store data.
- ex_addr_d / mem_addr_q  in/out  64  branch target address.
- ex_alu_flags_d / mem_alu_flags_q  in/out  4  combinational ALU flags, ordered {negative, zero, overflow, carryout}.
- ex_reg_flags_d / mem_reg_flags_q  in/out  4  flag-register outputs, same ordering.
- mem_rd_q, mem_m_ctl_q, mem_wb_ctl_q  out  5/5/2  EX/MEM copies of ex_rd_q, ex_m_ctl_q and ex_wb_ctl_q.

## Operation
- IF/ID captures if_instr_d and if_pc_d.
- ID/EX captures the id_* inputs, plus id_pc_q into ex_pc_q.
- EX/MEM captures the ex_*_d inputs, plus ex_rd_q, ex_m_ctl_q and ex_wb_ctl_q.
- All fields pass through bit-exact. There is no decoding, arithmetic or width conversion.
- When a stage's enable is 0, that stage holds all of its outputs (stall). The other stages are unaffected.
- Reset clears every output to 0. An all-zero control field is a bubble: no RegWrite, no MemRead/MemWrite, no branch, no flag update.
- There is no flush input. Bubbles are created only by reset, or by the producer driving zero control fields.
- Outputs are driven directly from flops. There is no combinational path from any input to any output.

## Timing
- Latency is one clock per stage.
- A value presented at if_pc_d reaches id_pc_q after edge 1 and ex_pc_q after edge 2, provided if_id_en and id_ex_en are high at both edges.
- id_rd_d reaches ex_rd_q after one edge and mem_rd_q after two edges. The M and WB control fields follow the same path.
- rst takes effect immediately, without waiting for a clock edge. Outputs stay 0 for as long as rst is 1.
- The first capture happens at the first rising edge after rst falls, if the stage's enable is high.
- rst has priority over enables: if rst is asserted during a clock edge, no capture occurs.
- When a stage's enable is low, the downstream stage still recaptures the held value each cycle. That downstream stage therefore repeats the value unless its own enable is also low.

## Test plan
- Reset: drive every input to nonzero values (e.g. if_pc_d=0x40, id_m_ctl_d=5'h1F) and assert rst mid-cycle -> every output is 0 immediately, with no clock edge required, and remains 0 until the first edge after rst falls.
- Flow-through with all enables high: if_pc_d=0x10, 0x14, 0x18 on consecutive edges -> id_pc_q=0x10 after edge 1; ex_pc_q=0x10 and id_pc_q=0x14 after edge 2.
- Control chaining: id_rd_d=5'd7, id_m_ctl_d=5'b01000, id_wb_ctl_d=2'b10 captured at edge n -> mem_rd_q=7, mem_m_ctl_q=5'b01000, mem_wb_ctl_q=2'b10 after edge n+1. At edge n+1 drive id_m_ctl_d=0 -> mem_m_ctl_q=0 after edge n+2.
- Stall: hold if_id_en=0 for 3 cycles while if_instr_d changes from 0xF84003E9 to 0x8B020020 -> id_instr_q stays 0xF84003E9. When enable returns to 1, id_instr_q=0x8B020020 after the next edge.
- EX/MEM data and flags: ex_alu_result_d=0xFFFF_FFFF_FFFF_FFFE, ex_alu_flags_d=4'b1000, ex_reg_flags_d=4'b0110, ex_addr_d=0x100 -> each appears unchanged at the corresponding mem_* output after one edge.
- Independent enables: ex_mem_en=0 while the other two enables are 1 -> mem_* outputs hold their values while ex_* outputs keep advancing.
